uart_tx_queue: RTL

//  Byte FIFO in front of UartTx. Lets the core/console write bursts without polling READY.

---
 rtl/uart_tx_queue_pkg.sv | 12 +
 rtl/uart_tx_queue_fifo.sv | 79 +++++++
 rtl/uart_tx_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the console transmit queue in front of UartTx.
package uart_tx_queue_pkg;

  localparam int TXQ_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// Byte storage with wrapping pointers and an occupancy counter; full/empty are registered.
module uart_tx_queue_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  flush,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            head
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int AW    = DEPTH_LOG2;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;

  // Accepted-push qualifier and next occupancy; a push is judged against the registered full flag.
  always_comb begin
    push_ok_s   = push && !full_r && !flush;
    count_nxt_s = count_r;
    case ({push_ok_s, pop})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and flag registers; flush drops everything not yet issued.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      wp_r    <= {AW{1'b0}};
      rp_r    <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else if (flush) begin
      rp_r    <= wp_r;
      count_r <= {CW{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wp_r <= wp_r + AW'(1);
      end
      if (pop) begin
        rp_r <= rp_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  // Storage write port; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wp_r] <= push_data;
    end
  end

  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;
  assign head  = mem_r[rp_r];

endmodule

// File: rtl/uart_tx_queue.sv
// Console byte queue metering bytes into UartTx over its DATA/WE/READY handshake.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  IN_WE,
  input  logic [7:0]            IN_DATA,
  input  logic                  FLUSH,
  input  logic                  OVF_CLR,
  output logic                  IN_FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVF,
  output logic [7:0]            TX_DATA,
  output logic                  TX_WE,
  input  logic                  TX_READY
);

  txq_state_e state_r;
  logic       pop_s;
  logic [7:0] head_s;
  logic       full_s;
  logic       empty_s;
  logic       ovf_r;
  logic       tx_we_r;
  logic [7:0] tx_data_r;

  uart_tx_queue_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .push      (IN_WE),
    .push_data (IN_DATA),
    .flush     (FLUSH),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (COUNT),
    .head      (head_s)
  );

  // Issue decision: only IDLE may take a byte, and a concurrent flush suppresses it.
  always_comb begin
    if ((state_r == ST_IDLE) && !empty_s && TX_READY && !FLUSH) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Sticky overflow; a dropped push outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      ovf_r <= 1'b0;
    end else if (IN_WE && full_s && !FLUSH) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end
  end

  // Handshake FSM: HOLD covers the edge on which UartTx has not yet dropped READY.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_r   <= ST_IDLE;
      tx_we_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            tx_data_r <= head_s;
            tx_we_r   <= 1'b1;
            state_r   <= ST_HOLD;
          end else begin
            tx_we_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          tx_we_r <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          tx_we_r <= 1'b0;
          if (TX_READY) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          tx_we_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign IN_FULL = full_s;
  assign EMPTY   = empty_s;
  assign OVF     = ovf_r;
  assign TX_DATA = tx_data_r;
  assign TX_WE   = tx_we_r;

endmodule
